// File: rtl/hififo_pattern_engine.sv
// Counter/PRBS pattern generator, fpc->tpc loopback and fpc receive checker for one
// hififo channel pair. Configured through four PIO registers starting at PIO_BASE.
module hififo_pattern_engine #(
  parameter int          WIDTH    = 64,
  parameter logic [12:0] PIO_BASE = 13'd16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pio_write_valid,
  input  logic [12:0]      pio_address,
  input  logic [63:0]      pio_write_data,
  output logic [WIDTH-1:0] tpc_data,
  output logic             tpc_write,
  input  logic             tpc_ready,
  input  logic [WIDTH-1:0] fpc_data,
  input  logic             fpc_empty,
  output logic             fpc_read,
  output logic [31:0]      tx_count,
  output logic [31:0]      rx_count,
  output logic [31:0]      err_count,
  output logic [WIDTH-1:0] first_err,
  output logic             gen_done
);

  localparam int         REPS      = WIDTH / 32;
  localparam logic [1:0] MODE_CNT  = 2'd0;
  localparam logic [1:0] MODE_PRBS = 2'd1;
  localparam logic [1:0] MODE_LOOP = 2'd2;
  localparam logic [1:0] MODE_OFF  = 2'd3;

  // One pattern step: x^31+x^28+1 Fibonacci LFSR shifting left, or a wrapping counter.
  function automatic logic [31:0] pat_step(input logic prbs, input logic [31:0] s);
    if (prbs) begin
      pat_step = {s[30:0], s[30] ^ s[27]};
    end else begin
      pat_step = s + 32'd1;
    end
  endfunction

  function automatic logic [WIDTH-1:0] pat_word(input logic prbs, input logic [31:0] s);
    if (prbs) begin
      pat_word = {REPS{s}};
    end else begin
      pat_word = '0;
      pat_word[31:0] = s;
    end
  endfunction

  function automatic logic [31:0] prbs_fix(input logic prbs, input logic [31:0] s);
    if (prbs && (s == 32'd0)) begin
      prbs_fix = 32'd1;
    end else begin
      prbs_fix = s;
    end
  endfunction

  logic [1:0]       mode_q, mode_d;
  logic             check_en_q, check_en_d;
  logic [31:0]      seed_q, seed_d, length_q, length_d, remaining_q, remaining_d;
  logic [31:0]      state_q, state_d, expected_q, expected_d;
  logic [31:0]      tx_count_q, tx_count_d, rx_count_q, rx_count_d, err_count_q, err_count_d;
  logic [WIDTH-1:0] first_err_q, first_err_d, tpc_data_q, tpc_data_d;
  logic             first_err_flag_q, first_err_flag_d;
  logic             tpc_write_q, tpc_write_d, gen_done_q, gen_done_d;

  logic wr_mode_s, wr_length_s, wr_seed_s, wr_clear_s;
  logic gen_prbs_s, gen_active_s, chk_pop_s, fpc_read_s;
  logic pio_unused_s;

  assign wr_mode_s    = pio_write_valid && (pio_address == PIO_BASE);
  assign wr_length_s  = pio_write_valid && (pio_address == PIO_BASE + 13'd1);
  assign wr_seed_s    = pio_write_valid && (pio_address == PIO_BASE + 13'd2);
  assign wr_clear_s   = pio_write_valid && (pio_address == PIO_BASE + 13'd3);
  assign pio_unused_s = ^pio_write_data[63:32];

  assign gen_prbs_s   = (mode_q == MODE_PRBS);
  assign gen_active_s = ((mode_q == MODE_CNT) || (mode_q == MODE_PRBS)) && tpc_ready &&
                        ((length_q == 32'd0) || (remaining_q != 32'd0));

  // fpc pop: loopback is throttled by tpc_ready, the checker drains freely.
  always_comb begin
    fpc_read_s = 1'b0;
    case (mode_q)
      MODE_LOOP:                     fpc_read_s = ~fpc_empty & tpc_ready;
      MODE_CNT, MODE_PRBS, MODE_OFF: fpc_read_s = check_en_q & ~fpc_empty;
      default:                       fpc_read_s = 1'b0;
    endcase
  end

  assign chk_pop_s = fpc_read_s && (mode_q != MODE_LOOP);

  // Next-state: generator/loopback, checker, PIO writes, counters (PIO length/clear win).
  always_comb begin
    mode_d           = mode_q;
    check_en_d       = check_en_q;
    seed_d           = seed_q;
    length_d         = length_q;
    remaining_d      = remaining_q;
    state_d          = state_q;
    expected_d       = expected_q;
    tx_count_d       = tx_count_q;
    rx_count_d       = rx_count_q;
    err_count_d      = err_count_q;
    first_err_d      = first_err_q;
    first_err_flag_d = first_err_flag_q;
    tpc_data_d       = tpc_data_q;
    tpc_write_d      = 1'b0;
    gen_done_d       = gen_done_q;

    if (gen_active_s) begin
      tpc_write_d = 1'b1;
      tpc_data_d  = pat_word(gen_prbs_s, state_q);
      state_d     = pat_step(gen_prbs_s, state_q);
      tx_count_d  = tx_count_q + 32'd1;
      if (length_q != 32'd0) begin
        remaining_d = remaining_q - 32'd1;
        if (remaining_q == 32'd1) begin
          gen_done_d = 1'b1;
        end else begin
          gen_done_d = gen_done_q;
        end
      end else begin
        remaining_d = remaining_q;
      end
    end else if ((mode_q == MODE_LOOP) && fpc_read_s) begin
      tpc_write_d = 1'b1;
      tpc_data_d  = fpc_data;
      tx_count_d  = tx_count_q + 32'd1;
    end else begin
      tpc_write_d = 1'b0;
    end

    if (chk_pop_s) begin
      rx_count_d = rx_count_q + 32'd1;
      if (fpc_data != pat_word(gen_prbs_s, expected_q)) begin
        if (err_count_q != 32'hFFFF_FFFF) begin
          err_count_d = err_count_q + 32'd1;
        end else begin
          err_count_d = err_count_q;
        end
        if (!first_err_flag_q) begin
          first_err_d      = fpc_data;
          first_err_flag_d = 1'b1;
        end else begin
          first_err_d      = first_err_q;
        end
        expected_d = pat_step(gen_prbs_s, prbs_fix(gen_prbs_s, fpc_data[31:0]));
      end else begin
        expected_d = pat_step(gen_prbs_s, expected_q);
      end
    end else begin
      expected_d = expected_d;
    end

    if (wr_mode_s) begin
      mode_d     = pio_write_data[1:0];
      check_en_d = pio_write_data[4];
    end else if (wr_length_s) begin
      length_d    = pio_write_data[31:0];
      remaining_d = pio_write_data[31:0];
      gen_done_d  = 1'b0;
      state_d     = prbs_fix(gen_prbs_s, seed_q);
      expected_d  = prbs_fix(gen_prbs_s, seed_q);
    end else if (wr_seed_s) begin
      seed_d = pio_write_data[31:0];
    end else if (wr_clear_s) begin
      tx_count_d       = 32'd0;
      rx_count_d       = 32'd0;
      err_count_d      = 32'd0;
      first_err_d      = '0;
      first_err_flag_d = 1'b0;
    end else begin
      mode_d = mode_d;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q           <= MODE_OFF;
      check_en_q       <= 1'b0;
      seed_q           <= 32'd0;
      length_q         <= 32'd0;
      remaining_q      <= 32'd0;
      state_q          <= 32'd0;
      expected_q       <= 32'd0;
      tx_count_q       <= 32'd0;
      rx_count_q       <= 32'd0;
      err_count_q      <= 32'd0;
      first_err_q      <= '0;
      first_err_flag_q <= 1'b0;
      tpc_data_q       <= '0;
      tpc_write_q      <= 1'b0;
      gen_done_q       <= 1'b0;
    end else begin
      mode_q           <= mode_d;
      check_en_q       <= check_en_d;
      seed_q           <= seed_d;
      length_q         <= length_d;
      remaining_q      <= remaining_d;
      state_q          <= state_d;
      expected_q       <= expected_d;
      tx_count_q       <= tx_count_d;
      rx_count_q       <= rx_count_d;
      err_count_q      <= err_count_d;
      first_err_q      <= first_err_d;
      first_err_flag_q <= first_err_flag_d;
      tpc_data_q       <= tpc_data_d;
      tpc_write_q      <= tpc_write_d;
      gen_done_q       <= gen_done_d;
    end
  end

  assign tpc_data  = tpc_data_q;
  assign tpc_write = tpc_write_q;
  assign fpc_read  = fpc_read_s;
  assign tx_count  = tx_count_q;
  assign rx_count  = rx_count_q;
  assign err_count = err_count_q;
  assign first_err = first_err_q;
  assign gen_done  = gen_done_q;

endmodule

// File: tb/tb_hififo_pattern_engine.sv
// Directed-vector bench for hififo_pattern_engine: generator, PRBS taps, loopback,
// checker resync, clear priority and mid-burst reset.
module tb_hififo_pattern_engine;
  logic        clock = 1'b0;
  logic        reset;
  logic        pio_write_valid;
  logic [12:0] pio_address;
  logic [63:0] pio_write_data;
  logic [63:0] tpc_data;
  logic        tpc_write;
  logic        tpc_ready;
  logic [63:0] fpc_data;
  logic        fpc_empty;
  logic        fpc_read;
  logic [31:0] tx_count, rx_count, err_count;
  logic [63:0] first_err;
  logic        gen_done;

  int vectors = 0;
  int miscompares = 0;
  int tx_exp = 0;

  localparam logic [12:0] A_MODE = 13'd16, A_LEN = 13'd17, A_SEED = 13'd18, A_CLR = 13'd19;

  hififo_pattern_engine #(.WIDTH(64), .PIO_BASE(13'd16)) dut (
    .clock(clock), .reset(reset), .pio_write_valid(pio_write_valid),
    .pio_address(pio_address), .pio_write_data(pio_write_data),
    .tpc_data(tpc_data), .tpc_write(tpc_write), .tpc_ready(tpc_ready),
    .fpc_data(fpc_data), .fpc_empty(fpc_empty), .fpc_read(fpc_read),
    .tx_count(tx_count), .rx_count(rx_count), .err_count(err_count),
    .first_err(first_err), .gen_done(gen_done)
  );

  always #5 clock = ~clock;

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one PIO write at a negedge; returns at the following negedge.
  task automatic pio_wr(input logic [12:0] addr, input logic [63:0] data);
    pio_write_valid = 1'b1;
    pio_address     = addr;
    pio_write_data  = data;
    @(negedge clock);
    pio_write_valid = 1'b0;
  endtask

  // Expect a burst of words on consecutive cycles, then idle with gen_done set.
  task automatic expect_burst(input string tag, input logic [63:0] w0, input logic [63:0] w1,
                              input logic [63:0] w2, input int n);
    logic [63:0] w [3];
    w[0] = w0; w[1] = w1; w[2] = w2;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check_vec({tag, "_wr"}, {63'd0, tpc_write}, 64'd1);
      check_vec({tag, "_data"}, tpc_data, w[i]);
      tx_exp++;
    end
    @(negedge clock);
    check_vec({tag, "_idle"}, {63'd0, tpc_write}, 64'd0);
    check_vec({tag, "_done"}, {63'd0, gen_done}, 64'd1);
    check_vec({tag, "_tx"}, {32'd0, tx_count}, 64'(tx_exp));
  endtask

  logic [31:0] tap_seed [3];
  logic [31:0] tap_next [3];
  logic        lb_empty [8];
  logic        lb_ready [8];
  logic [63:0] chk_data [5];

  initial begin
    reset = 1'b1; pio_write_valid = 1'b0; pio_address = 13'd0; pio_write_data = 64'd0;
    tpc_ready = 1'b0; fpc_data = 64'd0; fpc_empty = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_vec("rst_tpc_write", {63'd0, tpc_write}, 64'd0);
    check_vec("rst_tpc_data", tpc_data, 64'd0);
    check_vec("rst_counts", {tx_count, rx_count | err_count}, 64'd0);
    check_vec("rst_first_err", first_err, 64'd0);
    check_vec("rst_gen_done", {63'd0, gen_done}, 64'd0);
    check_vec("rst_fpc_read", {63'd0, fpc_read}, 64'd0);

    // Counter burst from seed 5
    tpc_ready = 1'b1;
    pio_wr(A_SEED, 64'd5);
    pio_wr(A_LEN, 64'd4);
    pio_wr(A_MODE, 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check_vec("cnt_wr", {63'd0, tpc_write}, 64'd1);
      check_vec("cnt_data", tpc_data, 64'(5 + i));
      tx_exp++;
    end
    @(negedge clock);
    check_vec("cnt_idle", {63'd0, tpc_write}, 64'd0);
    check_vec("cnt_done", {63'd0, gen_done}, 64'd1);
    check_vec("cnt_tx", {32'd0, tx_count}, 64'd4);

    // Counter wrap
    pio_wr(A_SEED, 64'hFFFF_FFFE);
    pio_wr(A_LEN, 64'd3);
    expect_burst("wrap", 64'h0000_0000_FFFF_FFFE, 64'h0000_0000_FFFF_FFFF, 64'd0, 3);

    // PRBS from seed 1 and seed 0 (loads as 1)
    pio_wr(A_MODE, 64'd1);
    pio_wr(A_SEED, 64'd1);
    pio_wr(A_LEN, 64'd3);
    expect_burst("prbs1", 64'h0000_0001_0000_0001, 64'h0000_0002_0000_0002,
                 64'h0000_0004_0000_0004, 3);
    pio_wr(A_SEED, 64'd0);
    pio_wr(A_LEN, 64'd3);
    expect_burst("prbs0", 64'h0000_0001_0000_0001, 64'h0000_0002_0000_0002,
                 64'h0000_0004_0000_0004, 3);

    // PRBS feedback taps (bit 30, bit 27, both)
    tap_seed[0] = 32'h4000_0000; tap_next[0] = 32'h8000_0001;
    tap_seed[1] = 32'h0800_0000; tap_next[1] = 32'h1000_0001;
    tap_seed[2] = 32'h4800_0000; tap_next[2] = 32'h9000_0000;
    for (int k = 0; k < 3; k++) begin
      pio_wr(A_SEED, {32'd0, tap_seed[k]});
      pio_wr(A_LEN, 64'd2);
      expect_burst("prbs_tap", {tap_seed[k], tap_seed[k]}, {tap_next[k], tap_next[k]}, 64'd0, 2);
    end

    // Loopback with fpc_empty toggling and tpc_ready low for 2 cycles
    pio_wr(A_MODE, 64'd2);
    lb_empty = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    lb_ready = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      logic pop;
      fpc_empty = lb_empty[i];
      tpc_ready = lb_ready[i];
      fpc_data  = 64'hA000 + 64'(i);
      pop = !lb_empty[i] && lb_ready[i];
      #1;
      check_vec("lb_fpc_read", {63'd0, fpc_read}, {63'd0, pop});
      @(negedge clock);
      check_vec("lb_tpc_write", {63'd0, tpc_write}, {63'd0, pop});
      if (pop) begin
        check_vec("lb_tpc_data", tpc_data, 64'hA000 + 64'(i));
        tx_exp++;
      end
    end
    fpc_empty = 1'b1;
    tpc_ready = 1'b1;
    check_vec("lb_tx", {32'd0, tx_count}, 64'(tx_exp));

    // Checker, counter pattern in mode off, expected starts at 10
    pio_wr(A_MODE, 64'h13);
    pio_wr(A_SEED, 64'd10);
    pio_wr(A_LEN, 64'd0);
    pio_wr(A_CLR, 64'd0);
    check_vec("clr_tx", {32'd0, tx_count}, 64'd0);
    chk_data = '{64'd10, 64'd11, 64'd99, 64'd100, 64'd101};
    for (int i = 0; i < 5; i++) begin
      fpc_empty = 1'b0;
      fpc_data  = chk_data[i];
      #1;
      check_vec("chk_fpc_read", {63'd0, fpc_read}, 64'd1);
      @(negedge clock);
    end
    fpc_empty = 1'b1;
    check_vec("chk_rx", {32'd0, rx_count}, 64'd5);
    check_vec("chk_err", {32'd0, err_count}, 64'd1);
    check_vec("chk_first_err", first_err, 64'd99);
    check_vec("chk_no_gen", {63'd0, tpc_write}, 64'd0);

    // Clear in the same cycle as a mismatching pop: clear wins
    fpc_empty = 1'b0;
    fpc_data  = 64'd500;
    pio_wr(A_CLR, 64'd0);
    fpc_empty = 1'b1;
    check_vec("clrpop_rx", {32'd0, rx_count}, 64'd0);
    check_vec("clrpop_err", {32'd0, err_count}, 64'd0);
    check_vec("clrpop_first", first_err, 64'd0);

    // Reset mid-burst
    pio_wr(A_LEN, 64'd100);
    pio_wr(A_MODE, 64'd0);
    repeat (3) @(negedge clock);
    check_vec("burst_running", {63'd0, tpc_write}, 64'd1);
    reset = 1'b1;
    @(negedge clock);
    check_vec("mrst_tpc_write", {63'd0, tpc_write}, 64'd0);
    check_vec("mrst_tpc_data", tpc_data, 64'd0);
    check_vec("mrst_tx", {32'd0, tx_count}, 64'd0);
    reset = 1'b0;
    fpc_empty = 1'b0;
    fpc_data = 64'd7;
    repeat (3) @(negedge clock);
    check_vec("post_rst_write", {63'd0, tpc_write}, 64'd0);
    check_vec("post_rst_fpc_read", {63'd0, fpc_read}, 64'd0);
    check_vec("post_rst_counts", {tx_count, rx_count}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
